dragon_chaser: RTL and testbench

//  Parametrised dragon AI. Replaces the fixed 16x16, head-only dragon logic.

---
 rtl/dragon_chaser.sv | 187 ++++++++++++++++++
 tb/tb_dragon_chaser.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dragon_chaser.sv
// Dragon AI: chases the player or sheep, retreats when struck, scatters after eating.
// The head moves one tile every MOVE_DIV enabled frames, and the body trails behind it.
module dragon_chaser #(
  parameter int unsigned          COORD_W    = 4,
  parameter int unsigned          MAX_LEN    = 8,
  parameter int unsigned          INIT_LEN   = 3,
  parameter int unsigned          MOVE_DIV   = 4,
  parameter int unsigned          RETREAT_FR = 32,
  parameter int unsigned          SCATTER_FR = 64,
  parameter logic [2*COORD_W-1:0] HEAD_INIT  = '0,
  parameter logic [15:0]          LFSR_SEED  = 16'hACE1,
  localparam int unsigned         LOC_W      = 2 * COORD_W,
  localparam int unsigned         LEN_W      = $clog2(MAX_LEN + 1)
) (
  input  logic                     frame_clk,
  input  logic                     rst,
  input  logic                     enable,
  input  logic [LOC_W-1:0]         player_loc,
  input  logic [LOC_W-1:0]         sheep_loc,
  input  logic                     sheep_eaten,
  input  logic                     dragon_hit,
  output logic [LOC_W-1:0]         head_loc,
  output logic [1:0]               head_dir,
  output logic [LEN_W-1:0]         body_len,
  output logic [MAX_LEN*LOC_W-1:0] body_locs,
  output logic [1:0]               mode,
  output logic                     step
);

  localparam int unsigned CNT_W = (MOVE_DIV > 1) ? $clog2(MOVE_DIV) : 1;
  localparam int unsigned TMR_W =
      $clog2(((RETREAT_FR > SCATTER_FR) ? RETREAT_FR : SCATTER_FR) + 1);

  localparam logic [1:0] DirUp    = 2'd0;
  localparam logic [1:0] DirRight = 2'd1;
  localparam logic [1:0] DirDown  = 2'd2;
  localparam logic [1:0] DirLeft  = 2'd3;

  typedef enum logic [1:0] {
    StContest = 2'd0,
    StRetreat = 2'd1,
    StScatter = 2'd2,
    StDead    = 2'd3
  } mode_t;

  mode_t                         mode_q;
  logic [CNT_W-1:0]              cnt_q;
  logic [TMR_W-1:0]              timer_q;
  logic [15:0]                   lfsr_q;
  logic [15:0]                   lfsr_nxt;
  logic [LOC_W-1:0]              scatter_tgt_q;
  logic [MAX_LEN-1:0][LOC_W-1:0] body_q;

  logic [COORD_W-1:0] hx, hy, px, py, sx, sy, tx, ty, nx, ny, adx, ady;
  logic [COORD_W:0]   dist_p, dist_s;
  logic [1:0]         nxt_dir;
  logic [LOC_W-1:0]   nxt_head;
  logic               fire, moving;

  function automatic logic [COORD_W-1:0] abs_diff(input logic [COORD_W-1:0] a,
                                                  input logic [COORD_W-1:0] b);
    return (a > b) ? a - b : b - a;
  endfunction

  assign {hx, hy} = head_loc;
  assign {px, py} = player_loc;
  assign {sx, sy} = sheep_loc;

  assign dist_p = {1'b0, abs_diff(px, hx)} + {1'b0, abs_diff(py, hy)};
  assign dist_s = {1'b0, abs_diff(sx, hx)} + {1'b0, abs_diff(sy, hy)};

  always_comb begin
    tx = sx;
    ty = sy;
    unique case (mode_q)
      StContest: begin
        // Ties go to the sheep.
        if (dist_p < dist_s) begin
          tx = px;
          ty = py;
        end
      end
      StRetreat: begin
        tx = px[COORD_W-1] ? '0 : '1;
        ty = py[COORD_W-1] ? '0 : '1;
      end
      StScatter: {tx, ty} = scatter_tgt_q;
      default: ;
    endcase
  end

  always_comb begin
    adx     = abs_diff(tx, hx);
    ady     = abs_diff(ty, hy);
    nx      = hx;
    ny      = hy;
    nxt_dir = head_dir;
    if (adx >= ady && adx != '0) begin
      nx      = (tx > hx) ? hx + 1'b1 : hx - 1'b1;
      nxt_dir = (tx > hx) ? DirRight : DirLeft;
    end else if (ady != '0) begin
      ny      = (ty > hy) ? hy + 1'b1 : hy - 1'b1;
      nxt_dir = (ty > hy) ? DirDown : DirUp;
    end
  end

  assign nxt_head = {nx, ny};
  assign fire     = (cnt_q == CNT_W'(MOVE_DIV - 1));
  assign moving   = fire && (nxt_head != head_loc);
  assign lfsr_nxt = lfsr_q[0] ? ((lfsr_q >> 1) ^ 16'hB400) : (lfsr_q >> 1);

  assign body_locs = body_q;
  assign mode      = mode_q;

  always_ff @(posedge frame_clk or posedge rst) begin
    if (rst) begin
      head_loc      <= HEAD_INIT;
      head_dir      <= DirRight;
      body_len      <= LEN_W'(INIT_LEN);
      body_q        <= {MAX_LEN{HEAD_INIT}};
      mode_q        <= StContest;
      step          <= 1'b0;
      cnt_q         <= '0;
      timer_q       <= '0;
      lfsr_q        <= LFSR_SEED;
      scatter_tgt_q <= '0;
    end else if (enable) begin
      if (mode_q == StDead) begin
        step <= 1'b0;
      end else begin
        lfsr_q <= lfsr_nxt;
        cnt_q  <= fire ? '0 : cnt_q + 1'b1;
        step   <= moving;
        if (moving) begin
          head_loc <= nxt_head;
          head_dir <= nxt_dir;
          body_q   <= {body_q[MAX_LEN-2:0], head_loc};
        end

        // Length reacts to events in every live mode; simultaneous pulses cancel.
        if (dragon_hit && !sheep_eaten) begin
          body_len <= body_len - 1'b1;
        end else if (sheep_eaten && !dragon_hit && body_len != LEN_W'(MAX_LEN)) begin
          body_len <= body_len + 1'b1;
        end

        if (dragon_hit && body_len == LEN_W'(1)) begin
          mode_q <= StDead;
        end else begin
          case (mode_q)
            StContest: begin
              if (dragon_hit) begin
                mode_q  <= StRetreat;
                timer_q <= TMR_W'(RETREAT_FR - 1);
              end else if (sheep_eaten) begin
                mode_q        <= StScatter;
                timer_q       <= TMR_W'(SCATTER_FR - 1);
                scatter_tgt_q <= lfsr_q[LOC_W-1:0];
              end
            end
            StRetreat: begin
              if (dragon_hit) begin
                timer_q <= TMR_W'(RETREAT_FR - 1);
              end else if (timer_q == '0) begin
                mode_q <= StContest;
              end else begin
                timer_q <= timer_q - 1'b1;
              end
            end
            StScatter: begin
              if (dragon_hit) begin
                mode_q  <= StRetreat;
                timer_q <= TMR_W'(RETREAT_FR - 1);
              end else if (timer_q == '0 || (moving && nxt_head == scatter_tgt_q)) begin
                mode_q <= StContest;
              end else begin
                timer_q <= timer_q - 1'b1;
              end
            end
            default: ;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_dragon_chaser.sv
// Self-checking bench for dragon_chaser: directed scenarios plus randomized frames
// compared against a coordinate-level behavioural model.
module tb_dragon_chaser;

  logic        frame_clk;
  logic        rst;
  logic        enable;
  logic [7:0]  player_loc;
  logic [7:0]  sheep_loc;
  logic        sheep_eaten;
  logic        dragon_hit;
  logic [7:0]  head_loc;
  logic [1:0]  head_dir;
  logic [3:0]  body_len;
  logic [63:0] body_locs;
  logic [1:0]  mode;
  logic        step;

  int checks   = 0;
  int failures = 0;

  dragon_chaser dut (
    .frame_clk  (frame_clk),
    .rst        (rst),
    .enable     (enable),
    .player_loc (player_loc),
    .sheep_loc  (sheep_loc),
    .sheep_eaten(sheep_eaten),
    .dragon_hit (dragon_hit),
    .head_loc   (head_loc),
    .head_dir   (head_dir),
    .body_len   (body_len),
    .body_locs  (body_locs),
    .mode       (mode),
    .step       (step)
  );

  initial frame_clk = 1'b0;
  always #5 frame_clk = ~frame_clk;

  // Behavioural model: x/y as integers, body as a list of tiles.
  int         m_hx, m_hy, m_dir, m_len, m_mode, m_cnt, m_timer;
  logic [7:0] m_stgt;
  logic [7:0] m_body [8];
  logic [15:0] m_lfsr;
  bit         m_step;

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  function automatic int sgn(input int v);
    return (v > 0) ? 1 : -1;
  endfunction

  function automatic logic [63:0] model_body();
    logic [63:0] v;
    for (int i = 0; i < 8; i++) v[i*8 +: 8] = m_body[i];
    return v;
  endfunction

  task automatic model_reset();
    m_hx = 0; m_hy = 0; m_dir = 1; m_len = 3; m_mode = 0; m_step = 0;
    m_cnt = 0; m_timer = 0; m_lfsr = 16'hACE1; m_stgt = 8'h00;
    for (int i = 0; i < 8; i++) m_body[i] = 8'h00;
  endtask

  task automatic model_frame(input bit en, input bit hit, input bit eaten,
                             input int p, input int s);
    int tx, ty, dx, dy, old_len;
    logic [15:0] lfsr_old;
    bit fire, moved;
    if (!en) return;
    if (m_mode == 3) begin
      m_step = 0;
      return;
    end
    tx = s / 16; ty = s % 16;
    if (m_mode == 0) begin
      if (iabs(p / 16 - m_hx) + iabs(p % 16 - m_hy) < iabs(s / 16 - m_hx) + iabs(s % 16 - m_hy)) begin
        tx = p / 16; ty = p % 16;
      end
    end else if (m_mode == 1) begin
      tx = (p / 16 < 8) ? 15 : 0;
      ty = (p % 16 < 8) ? 15 : 0;
    end else begin
      tx = m_stgt / 16; ty = m_stgt % 16;
    end
    lfsr_old = m_lfsr;
    m_lfsr = m_lfsr[0] ? ((m_lfsr >> 1) ^ 16'hB400) : (m_lfsr >> 1);
    fire = (m_cnt == 3);
    m_cnt = fire ? 0 : m_cnt + 1;
    moved = fire && (tx != m_hx || ty != m_hy);
    if (moved) begin
      for (int i = 7; i > 0; i--) m_body[i] = m_body[i-1];
      m_body[0] = 8'(m_hx * 16 + m_hy);
      dx = tx - m_hx; dy = ty - m_hy;
      if (iabs(dx) >= iabs(dy) && dx != 0) begin
        m_hx += sgn(dx); m_dir = (dx > 0) ? 1 : 3;
      end else begin
        m_hy += sgn(dy); m_dir = (dy > 0) ? 2 : 0;
      end
    end
    m_step = moved;
    old_len = m_len;
    if (hit && !eaten) m_len--;
    else if (eaten && !hit && m_len < 8) m_len++;
    if (hit && old_len == 1) m_mode = 3;
    else if (m_mode == 0) begin
      if (hit) begin m_mode = 1; m_timer = 31; end
      else if (eaten) begin m_mode = 2; m_timer = 63; m_stgt = lfsr_old[7:0]; end
    end else if (m_mode == 1) begin
      if (hit) m_timer = 31;
      else if (m_timer == 0) m_mode = 0;
      else m_timer--;
    end else if (m_mode == 2) begin
      if (hit) begin m_mode = 1; m_timer = 31; end
      else if (m_timer == 0 || (moved && m_hx == tx && m_hy == ty)) m_mode = 0;
      else m_timer--;
    end
  endtask

  task automatic do_reset();
    @(negedge frame_clk);
    rst = 1'b1;
    #2;
    rst = 1'b0;
    model_reset();
  endtask

  // Inputs are applied at the falling edge; outputs are sampled at the next falling edge.
  task automatic frame(input bit en, input bit hit, input bit eaten);
    enable = en; dragon_hit = hit; sheep_eaten = eaten;
    @(posedge frame_clk);
    model_frame(en, hit, eaten, int'(player_loc), int'(sheep_loc));
    @(negedge frame_clk);
    dragon_hit = 1'b0; sheep_eaten = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; enable = 1'b0; dragon_hit = 1'b0; sheep_eaten = 1'b0;
    player_loc = 8'h30; sheep_loc = 8'h05;
    #12;
    rst = 1'b0;
    model_reset();
    @(negedge frame_clk);
    checks++; if (head_loc !== 8'h00) begin failures++; $display("FAIL reset_head got=%h exp=00", head_loc); end
    checks++; if (head_dir !== 2'd1) begin failures++; $display("FAIL reset_dir got=%0d exp=1", head_dir); end
    checks++; if (body_len !== 4'd3) begin failures++; $display("FAIL reset_len got=%0d exp=3", body_len); end
    checks++; if (body_locs !== 64'h0) begin failures++; $display("FAIL reset_body got=%h exp=0", body_locs); end
    checks++; if (mode !== 2'd0) begin failures++; $display("FAIL reset_mode got=%0d exp=0", mode); end
    checks++; if (step !== 1'b0) begin failures++; $display("FAIL reset_step got=%b exp=0", step); end
  endtask

  task automatic test_chase();
    logic [7:0] exp_head;
    do_reset();
    player_loc = 8'h30; sheep_loc = 8'h05;
    for (int k = 1; k <= 12; k++) begin
      frame(1'b1, 1'b0, 1'b0);
      checks++;
      if (step !== 1'((k % 4) == 0)) begin
        failures++; $display("FAIL chase_step k=%0d got=%b exp=%b", k, step, (k % 4) == 0);
      end
      if ((k % 4) == 0) begin
        exp_head = 8'((k / 4) * 16);
        checks++; if (head_loc !== exp_head) begin failures++; $display("FAIL chase_head k=%0d got=%h exp=%h", k, head_loc, exp_head); end
        checks++; if (head_dir !== 2'd1) begin failures++; $display("FAIL chase_dir k=%0d got=%0d exp=1", k, head_dir); end
      end
    end
    checks++; if (body_locs[23:0] !== 24'h001020) begin failures++; $display("FAIL chase_body got=%h exp=001020", body_locs[23:0]); end
    frame(1'b1, 1'b0, 1'b0); frame(1'b1, 1'b0, 1'b0); frame(1'b1, 1'b0, 1'b0); frame(1'b1, 1'b0, 1'b0);
    checks++; if (step !== 1'b0 || head_loc !== 8'h30) begin failures++; $display("FAIL chase_on_target step=%b head=%h exp step=0 head=30", step, head_loc); end
  endtask

  task automatic test_tie();
    do_reset();
    player_loc = 8'h22; sheep_loc = 8'h40;
    for (int k = 0; k < 4; k++) frame(1'b1, 1'b0, 1'b0);
    checks++; if (head_loc !== 8'h10) begin failures++; $display("FAIL tie_head got=%h exp=10", head_loc); end
    checks++; if (head_dir !== 2'd1) begin failures++; $display("FAIL tie_dir got=%0d exp=1", head_dir); end
  endtask

  task automatic test_retreat();
    do_reset();
    player_loc = 8'h22; sheep_loc = 8'h40;
    frame(1'b1, 1'b1, 1'b0);
    checks++; if (mode !== 2'd1) begin failures++; $display("FAIL retreat_enter got=%0d exp=1", mode); end
    checks++; if (body_len !== 4'd2) begin failures++; $display("FAIL retreat_len got=%0d exp=2", body_len); end
    for (int k = 1; k <= 32; k++) begin
      frame(1'b1, 1'b0, 1'b0);
      checks++;
      if (mode !== ((k < 32) ? 2'd1 : 2'd0)) begin failures++; $display("FAIL retreat_mode k=%0d got=%0d", k, mode); end
      checks++;
      if (head_loc !== 8'(m_hx * 16 + m_hy)) begin failures++; $display("FAIL retreat_head k=%0d got=%h exp=%h", k, head_loc, 8'(m_hx * 16 + m_hy)); end
      if (k == 31) begin
        checks++; if (head_loc !== 8'h44) begin failures++; $display("FAIL retreat_walk got=%h exp=44", head_loc); end
      end
    end
  endtask

  task automatic test_scatter();
    int f;
    bit done;
    do_reset();
    player_loc = 8'hFF; sheep_loc = 8'hF0;
    for (int k = 0; k < 6; k++) frame(1'b1, 1'b0, 1'b1);
    f = 6;
    checks++; if (body_len !== 4'd8) begin failures++; $display("FAIL scatter_len got=%0d exp=8", body_len); end
    checks++; if (mode !== 2'd2) begin failures++; $display("FAIL scatter_mode got=%0d exp=2", mode); end
    done = 0;
    while (!done && f < 70) begin
      frame(1'b1, 1'b0, 1'b0);
      f++;
      checks++;
      if (head_loc !== 8'(m_hx * 16 + m_hy) || mode !== 2'(m_mode)) begin
        failures++; $display("FAIL scatter_track f=%0d head=%h mode=%0d exp head=%h mode=%0d", f, head_loc, mode, 8'(m_hx * 16 + m_hy), m_mode);
      end
      if (f == 59) begin
        checks++; if (mode !== 2'd2) begin failures++; $display("FAIL scatter_hold got=%0d exp=2", mode); end
      end
      if (f == 60) begin
        checks++; if (mode !== 2'd0 || head_loc !== 8'hE1) begin failures++; $display("FAIL scatter_arrive mode=%0d head=%h exp mode=0 head=e1", mode, head_loc); end
        done = 1;
      end
    end
  endtask

  task automatic test_dead();
    logic [7:0]  snap_head;
    logic [63:0] snap_body;
    logic [1:0]  snap_dir;
    do_reset();
    player_loc = 8'h22; sheep_loc = 8'h40;
    frame(1'b1, 1'b1, 1'b0);
    frame(1'b1, 1'b1, 1'b0);
    frame(1'b1, 1'b1, 1'b1);
    checks++; if (mode !== 2'd3) begin failures++; $display("FAIL dead_enter got=%0d exp=3", mode); end
    checks++; if (body_len !== 4'd1) begin failures++; $display("FAIL dead_len got=%0d exp=1", body_len); end
    snap_head = 8'(m_hx * 16 + m_hy); snap_body = model_body(); snap_dir = 2'(m_dir);
    for (int k = 0; k < 20; k++) begin
      player_loc = 8'($urandom_range(0, 255));
      frame(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      checks++;
      if (mode !== 2'd3 || body_len !== 4'd1 || head_loc !== snap_head || head_dir !== snap_dir ||
          body_locs !== snap_body || step !== 1'b0) begin
        failures++; $display("FAIL dead_hold k=%0d mode=%0d len=%0d head=%h step=%b exp head=%h", k, mode, body_len, head_loc, step, snap_head);
      end
    end
    do_reset();
    @(negedge frame_clk);
    checks++;
    if (mode !== 2'd0 || body_len !== 4'd3 || head_loc !== 8'h00 || head_dir !== 2'd1 || body_locs !== 64'h0) begin
      failures++; $display("FAIL dead_reset mode=%0d len=%0d head=%h dir=%0d", mode, body_len, head_loc, head_dir);
    end
  endtask

  task automatic test_enable();
    do_reset();
    player_loc = 8'h30; sheep_loc = 8'h05;
    frame(1'b1, 1'b0, 1'b0);
    frame(1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 10; k++) begin
      frame(1'b0, 1'(k == 5), 1'b0);
      checks++;
      if (step !== 1'b0 || head_loc !== 8'h00 || mode !== 2'd0 || body_len !== 4'd3) begin
        failures++; $display("FAIL enable_freeze k=%0d step=%b head=%h mode=%0d len=%0d", k, step, head_loc, mode, body_len);
      end
    end
    frame(1'b1, 1'b0, 1'b0);
    checks++; if (step !== 1'b0) begin failures++; $display("FAIL enable_resume1 got=%b exp=0", step); end
    frame(1'b1, 1'b0, 1'b0);
    checks++; if (step !== 1'b1 || head_loc !== 8'h10) begin failures++; $display("FAIL enable_resume2 step=%b head=%h exp step=1 head=10", step, head_loc); end
    frame(1'b1, 1'b0, 1'b1);
    for (int k = 0; k < 40; k++) begin
      frame(1'b1, 1'b0, 1'b0);
      checks++;
      if (head_loc !== 8'(m_hx * 16 + m_hy) || mode !== 2'(m_mode)) begin
        failures++; $display("FAIL enable_lfsr k=%0d head=%h mode=%0d exp head=%h mode=%0d", k, head_loc, mode, 8'(m_hx * 16 + m_hy), m_mode);
      end
    end
  endtask

  task automatic test_random();
    bit en, hit, eaten;
    do_reset();
    for (int f = 0; f < 600; f++) begin
      if ((m_mode == 3 && $urandom_range(0, 9) == 0) || $urandom_range(0, 199) == 0) do_reset();
      if ($urandom_range(0, 3) == 0) player_loc = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 5) == 0) sheep_loc = 8'($urandom_range(0, 255));
      en    = ($urandom_range(0, 7) != 0);
      hit   = ($urandom_range(0, 24) == 0);
      eaten = ($urandom_range(0, 14) == 0);
      frame(en, hit, eaten);
      checks++; if (head_loc !== 8'(m_hx * 16 + m_hy)) begin failures++; $display("FAIL rnd_head f=%0d got=%h exp=%h", f, head_loc, 8'(m_hx * 16 + m_hy)); end
      checks++; if (head_dir !== 2'(m_dir)) begin failures++; $display("FAIL rnd_dir f=%0d got=%0d exp=%0d", f, head_dir, m_dir); end
      checks++; if (body_len !== 4'(m_len)) begin failures++; $display("FAIL rnd_len f=%0d got=%0d exp=%0d", f, body_len, m_len); end
      checks++; if (body_locs !== model_body()) begin failures++; $display("FAIL rnd_body f=%0d got=%h exp=%h", f, body_locs, model_body()); end
      checks++; if (mode !== 2'(m_mode)) begin failures++; $display("FAIL rnd_mode f=%0d got=%0d exp=%0d", f, mode, m_mode); end
      checks++; if (step !== m_step) begin failures++; $display("FAIL rnd_step f=%0d got=%b exp=%b", f, step, m_step); end
    end
  endtask

  initial begin
    test_reset();
    test_chase();
    test_tie();
    test_retreat();
    test_scatter();
    test_dead();
    test_enable();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
